dcache_wb: RTL

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_if.sv | 24 ++
 rtl/dcache_plru.sv | 26 ++
 rtl/dcache_wb.sv | 108 ++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type, default parameters and derived-width helpers
package dcache_pkg;
    localparam int SETS_D        = 16;
    localparam int WAYS_D        = 4;
    localparam int BLOCK_BYTES_D = 16;
    localparam int ADDR_W_D      = 28;

    typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    function automatic int blk_w(input int bytes);
        return 8 * bytes;
    endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: cpu request/response and memory transfer bus of the write-back cache
//   slave  : the cache (takes cpu requests, issues memory transfers)
//   master : the environment (cpu requester + memory responder)
interface dcache_if import dcache_pkg::*; #(
    parameter int ADDR_W      = ADDR_W_D,
    parameter int BLOCK_BYTES = BLOCK_BYTES_D
);
    logic                     cpu_req, cpu_we, cpu_ready;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [BLOCK_BYTES-1:0]   cpu_be;
    logic [8*BLOCK_BYTES-1:0] cpu_wdata, cpu_rdata;
    logic                     mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]        mem_addr;
    logic [8*BLOCK_BYTES-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_plru.sv
// dcache_plru: victim select and MRU-bit next state for one set
//   valid, mru : per-way state of the set
//   acc        : way being accessed (hit or refill)
//   victim     : lowest invalid way, else lowest way with MRU=0
//   mru_next   : MRU bits after marking acc; rolls over to only acc when all would be set
module dcache_plru #(
    parameter int WAYS = 4,
    parameter int WW   = $clog2(WAYS)
) (
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] mru,
    input  logic [WW-1:0]   acc,
    output logic [WW-1:0]   victim,
    output logic [WAYS-1:0] mru_next
);
    logic [WAYS-1:0] mru_set;

    // Descending scans so the lowest index wins; an invalid way overrides the MRU choice.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) if (!mru[w]) victim = WW'(w);
        for (int w = WAYS - 1; w >= 0; w--) if (!valid[w]) victim = WW'(w);
        mru_set  = mru | (WAYS'(1) << acc);
        mru_next = &mru_set ? WAYS'(1) << acc : mru_set;
    end
endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: set-associative write-back, write-allocate data cache
//   clk, rst : clock, synchronous active-high reset
//   bus      : dcache_if.slave -- cpu request/response and memory write-back/refill
module dcache_wb import dcache_pkg::*; #(
    parameter int SETS        = SETS_D,
    parameter int WAYS        = WAYS_D,
    parameter int BLOCK_BYTES = BLOCK_BYTES_D,
    parameter int ADDR_W      = ADDR_W_D
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(ADDR_W, SETS);
    localparam int BW = blk_w(BLOCK_BYTES);
    localparam int WW = $clog2(WAYS);

    logic [SETS-1:0][WAYS-1:0] valid, dirty, mru;
    logic [TW-1:0]             tag_a  [SETS][WAYS];
    logic [BW-1:0]             data_a [SETS][WAYS];
    state_t                    state, state_n;
    logic [WW-1:0]             hit_way, vic_way, vic_q, acc_way;
    logic [IW-1:0]             idx, idx_q, set_i;
    logic [TW-1:0]             tag;
    logic                      hit, vic_dirty;
    logic [BW-1:0]             merged;
    logic [WAYS-1:0]           mru_next;

    assign idx       = bus.cpu_addr[IW-1:0];
    assign tag       = bus.cpu_addr[ADDR_W-1:IW];
    assign set_i     = state == IDLE ? idx : idx_q;
    assign acc_way   = state == REFILL ? vic_q : hit_way;
    assign vic_dirty = valid[idx][vic_way] && dirty[idx][vic_way];

    assign bus.cpu_ready = state == DONE;
    assign bus.mem_req   = state == WB || state == REFILL;
    assign bus.mem_we    = state == WB;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid[idx][w] && tag_a[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        merged = data_a[idx][hit_way];
        for (int b = 0; b < BLOCK_BYTES; b++)
            if (bus.cpu_be[b]) merged[8*b +: 8] = bus.cpu_wdata[8*b +: 8];
    end

    dcache_plru #(.WAYS(WAYS), .WW(WW)) u_plru (
        .valid    (valid[set_i]),
        .mru      (mru[set_i]),
        .acc      (acc_way),
        .victim   (vic_way),
        .mru_next (mru_next)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !bus.cpu_req ? IDLE : hit ? DONE : vic_dirty ? WB : REFILL;
            WB:      state_n = bus.mem_ack ? REFILL : WB;
            REFILL:  state_n = bus.mem_ack ? IDLE : REFILL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            dirty         <= '0;
            mru           <= '0;
            bus.cpu_rdata <= '0;
        end else begin
            if (state == IDLE && bus.cpu_req && hit) begin
                bus.cpu_rdata <= bus.cpu_we ? merged : data_a[idx][hit_way];
                if (bus.cpu_we) begin
                    data_a[idx][hit_way] <= merged;
                    dirty[idx][hit_way]  <= 1'b1;
                end
                mru[idx] <= mru_next;
            end
            // Victim and set are frozen here so WB/REFILL never re-evaluate replacement.
            if (state == IDLE && bus.cpu_req && !hit) begin
                vic_q         <= vic_way;
                idx_q         <= idx;
                bus.mem_addr  <= vic_dirty ? {tag_a[idx][vic_way], idx} : bus.cpu_addr;
                bus.mem_wdata <= data_a[idx][vic_way];
            end
            if (state == WB && bus.mem_ack) begin
                dirty[idx_q][vic_q] <= 1'b0;
                bus.mem_addr        <= bus.cpu_addr;
            end
            if (state == REFILL && bus.mem_ack) begin
                valid[idx_q][vic_q]  <= 1'b1;
                dirty[idx_q][vic_q]  <= 1'b0;
                tag_a[idx_q][vic_q]  <= tag;
                data_a[idx_q][vic_q] <= bus.mem_rdata;
                mru[idx_q]           <= mru_next;
            end
        end
    end
endmodule
